// File: rtl/siggen_pkg.sv
// Shared types for the signal-generator output stages.
package siggen_pkg;

  typedef enum logic [2:0] {
    OFF,
    LOW,
    DT_LH,
    HIGH,
    DT_HL
  } dt_state_t;

  localparam int DT_W_DEFAULT = 8;

endpackage

// File: rtl/pwm_deadtime_dt_timer.sv
// Loadable down-counter for the dead interval; holds at zero rather than wrapping.
module dt_timer #(
  parameter int W = 8
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low drive from a single-ended PWM bit with programmable dead time.
//   state | meaning
//   OFF   | disabled, both outputs low
//   LOW   | low side on
//   DT_LH | dead interval before high side turns on
//   HIGH  | high side on
//   DT_HL | dead interval before low side turns on
module pwm_deadtime
  import siggen_pkg::*;
#(
  parameter int W = DT_W_DEFAULT
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         en,
  input  logic         pwm,
  input  logic [W-1:0] dt,
  output logic         pwm_h,
  output logic         pwm_l,
  output logic         dt_active
);

  dt_state_t    state_q, state_d;
  logic         pwm_q;
  logic         pwm_h_q, pwm_l_q, dt_active_q;
  logic         tmr_load, tmr_dec, tmr_zero;
  logic [W-1:0] tmr_val;

  // Counter loads dt-1 so the dead interval lasts exactly dt cycles.
  assign tmr_val = dt - W'(1);

  dt_timer #(.W(W)) u_dt_timer (
    .clk50m (clk50m),
    .rst    (rst),
    .load   (tmr_load),
    .val    (tmr_val),
    .dec    (tmr_dec),
    .zero   (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (!en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: state_d = pwm_q ? HIGH : LOW;
        LOW: begin
          if (pwm_q) begin
            if (dt != '0) begin
              state_d  = DT_LH;
              tmr_load = 1'b1;
            end else begin
              state_d = HIGH;
            end
          end
        end
        HIGH: begin
          if (!pwm_q) begin
            if (dt != '0) begin
              state_d  = DT_HL;
              tmr_load = 1'b1;
            end else begin
              state_d = LOW;
            end
          end
        end
        DT_LH: begin
          if (!pwm_q) begin
            state_d = LOW;
          end else if (tmr_zero) begin
            state_d = HIGH;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        DT_HL: begin
          if (pwm_q) begin
            state_d = HIGH;
          end else if (tmr_zero) begin
            state_d = LOW;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q     <= OFF;
      pwm_q       <= 1'b0;
      pwm_h_q     <= 1'b0;
      pwm_l_q     <= 1'b0;
      dt_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_q       <= pwm;
      pwm_h_q     <= (state_d == HIGH);
      pwm_l_q     <= (state_d == LOW);
      dt_active_q <= (state_d == DT_LH) || (state_d == DT_HL);
    end
  end

  assign pwm_h     = pwm_h_q;
  assign pwm_l     = pwm_l_q;
  assign dt_active = dt_active_q;

endmodule
